// File: rtl/key_intake.sv
// key_intake: consumer side of the TRNG key interface.
// Captures, health-tests and hands off one key at a time.
module key_intake #(
  parameter int KEY_W      = 10,
  parameter int MAX_REJECT = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [KEY_W-1:0] gen_key,
  input  logic             gen_ready,
  output logic             gen_restart,
  input  logic             key_req,
  output logic             key_ack,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  input  logic             clear_fault,
  output logic             fault,
  output logic [7:0]       reject_cnt
);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_WAIT,
    S_CHECK,
    S_FULL,
    S_FAULT
  } state_t;

  localparam logic [8:0] MAX_R = 9'(MAX_REJECT);

  state_t           state_q, state_d;
  logic             ready_q;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] last_q, last_d;
  logic             have_last_q, have_last_d;
  logic             gen_restart_q, gen_restart_d;
  logic             key_ack_q, key_ack_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic             key_valid_q, key_valid_d;
  logic             fault_q, fault_d;
  logic [7:0]       reject_cnt_q, reject_cnt_d;

  logic       rise;
  logic       bad_key;
  logic [8:0] cnt_inc;

  assign rise    = gen_ready & ~ready_q;
  assign cnt_inc = {1'b0, reject_cnt_q} + 9'd1;
  assign bad_key = (cand_q == '0) || (cand_q == '1) ||
                   (have_last_q && (cand_q == last_q));

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    last_d        = last_q;
    have_last_d   = have_last_q;
    gen_restart_d = 1'b0;
    key_ack_d     = 1'b0;
    key_out_d     = key_out_q;
    key_valid_d   = key_valid_q;
    fault_d       = fault_q;
    reject_cnt_d  = reject_cnt_q;
    unique case (state_q)
      S_EMPTY: begin
        key_out_d     = '0;
        gen_restart_d = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (rise) begin
          cand_d  = gen_key;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_key) begin
          reject_cnt_d = cnt_inc[8] ? 8'hFF : cnt_inc[7:0];
          if (cnt_inc >= MAX_R) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            state_d = S_EMPTY;
          end
        end else begin
          key_out_d    = cand_q;
          last_d       = cand_q;
          have_last_d  = 1'b1;
          reject_cnt_d = '0;
          key_valid_d  = 1'b1;
          state_d      = S_FULL;
        end
      end
      S_FULL: begin
        if (key_req) begin
          key_ack_d   = 1'b1;
          key_valid_d = 1'b0;
          state_d     = S_EMPTY;
        end
      end
      S_FAULT: begin
        key_out_d   = '0;
        key_valid_d = 1'b0;
        if (clear_fault) begin
          fault_d      = 1'b0;
          reject_cnt_d = '0;
          state_d      = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_EMPTY;
      ready_q       <= 1'b0;
      cand_q        <= '0;
      last_q        <= '0;
      have_last_q   <= 1'b0;
      gen_restart_q <= 1'b0;
      key_ack_q     <= 1'b0;
      key_out_q     <= '0;
      key_valid_q   <= 1'b0;
      fault_q       <= 1'b0;
      reject_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= gen_ready;
      cand_q        <= cand_d;
      last_q        <= last_d;
      have_last_q   <= have_last_d;
      gen_restart_q <= gen_restart_d;
      key_ack_q     <= key_ack_d;
      key_out_q     <= key_out_d;
      key_valid_q   <= key_valid_d;
      fault_q       <= fault_d;
      reject_cnt_q  <= reject_cnt_d;
    end
  end

  assign gen_restart = gen_restart_q;
  assign key_ack     = key_ack_q;
  assign key_out     = key_out_q;
  assign key_valid   = key_valid_q;
  assign fault       = fault_q;
  assign reject_cnt  = reject_cnt_q;

endmodule

// File: doc/key_intake.md
Name: key_intake

Overview:
- Consumer end of the TRNG key interface: watches the generator's `key`/`ready` outputs and captures each freshly produced 10-bit key.
- Runs per-key health tests on the captured value and holds at most one approved key.
- Hands the approved key to a downstream requester over a req/ack handshake, exactly once per key.
- After each hand-off or rejection, pulses a restart request so the generator produces a new key; too many consecutive rejections latch a sticky fault.

Parameters:
- KEY_W, 10, key width; must equal the generator's key width.
- MAX_REJECT, 8, number of consecutive rejected keys that latches FAULT (range 1..255).

Ports:
- clk  input  1  system clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- gen_key  input  KEY_W  key bus from generator, sampled only on a ready rising edge
- gen_ready  input  1  generator key-ready flag (level), treated as edge-significant
- gen_restart  output  1  one-cycle pulse asking the generator for a new key
- key_req  input  1  downstream request (level), held until key_ack
- key_ack  output  1  one-cycle pulse: key_out valid this cycle, key consumed
- key_out  output  KEY_W  approved key; zero whenever no key is held
- key_valid  output  1  an approved key is held (state FULL)
- clear_fault  input  1  leaves FAULT (one-cycle pulse expected)
- fault  output  1  sticky health-test failure flag
- reject_cnt  output  8  consecutive rejects since last accept or clear

Behaviour:
- Reset (rstn low, asynchronous) sets:
  - outputs: gen_restart=0, key_ack=0, key_out=0, key_valid=0, fault=0, reject_cnt=0
  - internal: state=EMPTY, ready_q=0, cand=0, last_key=0, have_last=0
- Ready edge detect: ready_q <= gen_ready every cycle in all states. rise = gen_ready & ~ready_q.
- FSM states: EMPTY, WAIT, CHECK, FULL, FAULT.
- EMPTY:
  - key_out <= 0 (zeroize).
  - Next edge: gen_restart <= 1, go to WAIT.
  - gen_restart is high only in the first cycle of WAIT.
- WAIT:
  - gen_restart <= 0.
  - On rise: cand <= gen_key, go to CHECK.
  - Rises in any other state are ignored (but ready_q still tracks).
- CHECK (exactly one cycle). Reject if any of:
  - cand == 0
  - cand == all-ones
  - have_last && cand == last_key (repetition test)
- CHECK, on reject:
  - reject_cnt <= reject_cnt+1, saturating at 255.
  - If reject_cnt+1 >= MAX_REJECT: fault <= 1, go to FAULT.
  - Otherwise go to EMPTY (which issues a new restart).
- CHECK, on accept:
  - key_out <= cand, last_key <= cand, have_last <= 1.
  - reject_cnt <= 0, key_valid <= 1, go to FULL.
- Latency: rise sampled at edge N gives key_valid=1 after edge N+1.
- FULL:
  - If key_req is sampled high at edge M: key_ack <= 1, key_valid <= 0, go to EMPTY. key_out keeps the key during the ack cycle (after M), and is 0 after M+1.
  - key_ack is never high two consecutive cycles.
  - The requester must drop key_req after ack. If key_req is still high in the following EMPTY/WAIT/CHECK it is ignored, and FULL serves it on the next key.
- key_req outside FULL: no ack, no state effect.
- FAULT:
  - key_valid=0, key_out=0, gen_restart=0, fault=1.
  - key_req and rise are ignored.
  - clear_fault high: fault <= 0, reject_cnt <= 0, go to EMPTY.
  - have_last and last_key are kept, so the repetition test persists across clear.
- clear_fault outside FAULT: no effect.
- key_req and clear_fault are never simultaneously meaningful; FAULT priority applies only in FAULT.
- Reset mid-operation (any state): immediate return to reset values; a held key is lost and zeroized.
- Widths: comparisons on full KEY_W. reject_cnt is 8-bit saturating; the compare uses reject_cnt+1 computed in 9 bits.

Test Plan:
- Reset release, gen_ready rises with gen_key=10'h2A5 -> one gen_restart pulse in the first cycle after reset; key_valid=1 two edges after rise; key_out=10'h2A5; reject_cnt=0.
- FULL with 10'h2A5, key_req held high -> key_ack high exactly one cycle with key_out=10'h2A5; then key_valid=0, key_out=0, and a new gen_restart pulse one cycle later.
- Keys 10'h000, then 10'h3FF, then 10'h2A5 (equal to last accepted) -> each rejected; reject_cnt goes 1,2,3; gen_restart pulses after each; key_valid stays 0. Then 10'h155 -> accepted, reject_cnt=0.
- MAX_REJECT=8, eight consecutive 10'h000 keys -> fault=1 after the eighth CHECK, no further gen_restart. gen_ready rises and key_req are ignored. clear_fault pulse -> fault=0, reject_cnt=0, gen_restart pulse.
- key_req high from reset before any key; gen_ready held high for 5 cycles -> only one capture; no ack until FULL; ack follows one edge after key_valid.
- rstn asserted while FULL (key 10'h155) -> key_out=0, key_valid=0 immediately, without waiting for clk. After release the repetition test is cleared, so 10'h155 is accepted.
